exception_controller: RTL and testbench

//  Central exception/interrupt sequencer for the 5-stage pipeline. Collects

---
 rtl/exception_controller_pkg.sv | 28 ++
 rtl/exception_controller_if.sv | 51 +++++
 rtl/exception_controller_irq_sync.sv | 21 ++
 rtl/exception_controller.sv | 113 +++++++++++
 tb/tb_exception_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/exception_controller_pkg.sv
// Shared exception codes, FSM encoding and the per-cycle take descriptor
// used by the exception controller.
package exception_controller_pkg;

    localparam logic [31:0] HANDLER_VEC_DEF = 32'h8000_0180;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } state_e;

    // flush is {MEM, EX, ID, IF}
    typedef struct packed {
        logic        take;
        logic [4:0]  code;
        logic [3:0]  flush;
        logic [31:0] pc;
    } take_t;

endpackage

// File: rtl/exception_controller_if.sv
// Pipeline <-> exception controller signal bundle.
interface exception_controller_if #(parameter int IRQ_W = 6);

    logic             Stall;
    logic             Exc_IF_AdEL;
    logic [31:0]      PC_IF;
    logic             Exc_ID_RI;
    logic             Exc_ID_Sys;
    logic             Exc_ID_Brk;
    logic             Eret_ID;
    logic [31:0]      PC_ID;
    logic             Exc_EX_Ov;
    logic [31:0]      PC_EX;
    logic             Exc_MEM_AdEL;
    logic             Exc_MEM_AdES;
    logic [31:0]      PC_MEM;
    logic [IRQ_W-1:0] IRQ;
    logic [IRQ_W-1:0] IRQ_Mask;
    logic [31:0]      EPC_In;

    logic             EPC_Enable;
    logic [31:0]      EPC_PC;
    logic [4:0]       Cause_ExcCode;
    logic             Status_EXL;
    logic             Flush_IF;
    logic             Flush_ID;
    logic             Flush_EX;
    logic             Flush_MEM;
    logic             PC_Redirect;
    logic [31:0]      Redirect_Target;
    logic [7:0]       Exc_Count;

    modport master (
        output Stall, Exc_IF_AdEL, PC_IF, Exc_ID_RI, Exc_ID_Sys, Exc_ID_Brk,
               Eret_ID, PC_ID, Exc_EX_Ov, PC_EX, Exc_MEM_AdEL, Exc_MEM_AdES,
               PC_MEM, IRQ, IRQ_Mask, EPC_In,
        input  EPC_Enable, EPC_PC, Cause_ExcCode, Status_EXL, Flush_IF,
               Flush_ID, Flush_EX, Flush_MEM, PC_Redirect, Redirect_Target,
               Exc_Count
    );

    modport slave (
        input  Stall, Exc_IF_AdEL, PC_IF, Exc_ID_RI, Exc_ID_Sys, Exc_ID_Brk,
               Eret_ID, PC_ID, Exc_EX_Ov, PC_EX, Exc_MEM_AdEL, Exc_MEM_AdES,
               PC_MEM, IRQ, IRQ_Mask, EPC_In,
        output EPC_Enable, EPC_PC, Cause_ExcCode, Status_EXL, Flush_IF,
               Flush_ID, Flush_EX, Flush_MEM, PC_Redirect, Redirect_Target,
               Exc_Count
    );

endinterface

// File: rtl/exception_controller_irq_sync.sv
// Per-bit flop chain bringing the asynchronous IRQ lines into the CLK domain.
module irq_synchronizer #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_chain <= '0;
        else      r_chain <= {r_chain[STAGES-2:0], i_async};
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/exception_controller.sv
// Oldest-first exception/IRQ arbitration, EPC/flush/redirect generation and
// the NORMAL/HANDLER sequencer that owns Status.EXL and Cause.
module exception_controller
    import exception_controller_pkg::*;
#(
    parameter logic [31:0] HANDLER_VEC = HANDLER_VEC_DEF,
    parameter int          IRQ_W       = 6,
    parameter int          SYNC_STAGES = 2
) (
    input logic                   CLK,
    input logic                   RST,
    exception_controller_if.slave bus
);

    state_e           r_state, w_state_nxt;
    logic [4:0]       r_cause;
    logic [7:0]       r_count;
    logic [IRQ_W-1:0] w_irq_sync;
    logic             w_irq_pend, w_id_ok, w_eret;
    take_t            w_take;

    logic             w_epc_en, w_redirect;
    logic [31:0]      w_epc_pc, w_target;
    logic [3:0]       w_flush;

    irq_synchronizer #(.WIDTH(IRQ_W), .STAGES(SYNC_STAGES)) u_irq_sync (
        .CLK     (CLK),
        .RST     (RST),
        .i_async (bus.IRQ),
        .o_sync  (w_irq_sync)
    );

    assign w_irq_pend = (|(w_irq_sync & bus.IRQ_Mask)) && (r_state == ST_NORMAL);
    assign w_id_ok    = !bus.Stall;

    // Oldest stage first; an ERET outside the handler decodes as RI.
    always_comb begin
        w_take = '0;
        w_eret = 1'b0;
        if (bus.Exc_MEM_AdEL)
            w_take = '{1'b1, EXC_ADEL, 4'b1111, bus.PC_MEM};
        else if (bus.Exc_MEM_AdES)
            w_take = '{1'b1, EXC_ADES, 4'b1111, bus.PC_MEM};
        else if (w_irq_pend)
            w_take = '{1'b1, EXC_INT, 4'b0111, bus.PC_EX};
        else if (bus.Exc_EX_Ov)
            w_take = '{1'b1, EXC_OV, 4'b0111, bus.PC_EX};
        else if (w_id_ok && (bus.Exc_ID_RI || (bus.Eret_ID && r_state == ST_NORMAL)))
            w_take = '{1'b1, EXC_RI, 4'b0011, bus.PC_ID};
        else if (w_id_ok && bus.Exc_ID_Sys)
            w_take = '{1'b1, EXC_SYS, 4'b0011, bus.PC_ID};
        else if (w_id_ok && bus.Exc_ID_Brk)
            w_take = '{1'b1, EXC_BP, 4'b0011, bus.PC_ID};
        else if (w_id_ok && bus.Eret_ID)
            w_eret = 1'b1;
        else if (w_id_ok && bus.Exc_IF_AdEL)
            w_take = '{1'b1, EXC_ADEL, 4'b0001, bus.PC_IF};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_NORMAL;
            r_cause <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take.take) begin
                r_cause <= w_take.code;
                if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            end
        end
    end

    // Strobes are forced low while reset is held so nothing redirects.
    always_comb begin
        w_state_nxt = r_state;
        w_epc_en    = 1'b0;
        w_epc_pc    = '0;
        w_flush     = '0;
        w_redirect  = 1'b0;
        w_target    = '0;
        if (RST) begin
            if (w_take.take) begin
                w_state_nxt = ST_HANDLER;
                w_flush     = w_take.flush;
                w_redirect  = 1'b1;
                w_target    = HANDLER_VEC;
                if (r_state == ST_NORMAL) begin
                    w_epc_en = 1'b1;
                    w_epc_pc = w_take.pc;
                end
            end else if (w_eret) begin
                w_state_nxt = ST_NORMAL;
                w_flush     = 4'b0001;
                w_redirect  = 1'b1;
                w_target    = bus.EPC_In;
            end
        end
    end

    assign bus.EPC_Enable      = w_epc_en;
    assign bus.EPC_PC          = w_epc_pc;
    assign bus.Flush_IF        = w_flush[0];
    assign bus.Flush_ID        = w_flush[1];
    assign bus.Flush_EX        = w_flush[2];
    assign bus.Flush_MEM       = w_flush[3];
    assign bus.PC_Redirect     = w_redirect;
    assign bus.Redirect_Target = w_target;
    assign bus.Cause_ExcCode   = r_cause;
    assign bus.Status_EXL      = (r_state == ST_HANDLER);
    assign bus.Exc_Count       = r_count;

endmodule

// File: tb/tb_exception_controller.sv
// Directed checks of arbitration, EPC/flush/redirect, ERET, IRQ sync latency,
// stall gating, counter saturation and asynchronous reset.
module tb_exception_controller;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    exception_controller_if #(.IRQ_W(6)) bus ();

    exception_controller #(
        .HANDLER_VEC (32'h8000_0180),
        .IRQ_W       (6),
        .SYNC_STAGES (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    localparam logic [31:0] VEC = 32'h8000_0180;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational strobes: {EPC_Enable, EPC_PC, flush{MEM,EX,ID,IF}, redirect, target}
    task automatic chk_comb(input string tag, input logic en, input logic [31:0] epc,
                            input logic [3:0] fl, input logic rd, input logic [31:0] tgt);
        chk({tag, ".epc_en"}, {31'd0, bus.EPC_Enable}, {31'd0, en});
        chk({tag, ".epc_pc"}, bus.EPC_PC, epc);
        chk({tag, ".flush"}, {28'd0, bus.Flush_MEM, bus.Flush_EX, bus.Flush_ID, bus.Flush_IF}, {28'd0, fl});
        chk({tag, ".redir"}, {31'd0, bus.PC_Redirect}, {31'd0, rd});
        chk({tag, ".target"}, bus.Redirect_Target, tgt);
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] cause, input logic exl, input logic [7:0] cnt);
        chk({tag, ".cause"}, {27'd0, bus.Cause_ExcCode}, {27'd0, cause});
        chk({tag, ".exl"}, {31'd0, bus.Status_EXL}, {31'd0, exl});
        chk({tag, ".count"}, {24'd0, bus.Exc_Count}, {24'd0, cnt});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_flags();
        bus.Stall = 0; bus.Exc_IF_AdEL = 0; bus.Exc_ID_RI = 0; bus.Exc_ID_Sys = 0;
        bus.Exc_ID_Brk = 0; bus.Eret_ID = 0; bus.Exc_EX_Ov = 0;
        bus.Exc_MEM_AdEL = 0; bus.Exc_MEM_AdES = 0;
    endtask

    task automatic leave_handler(input logic [31:0] epc);
        bus.Eret_ID = 1; bus.EPC_In = epc;
        tick();
        bus.Eret_ID = 0;
    endtask

    initial begin
        clear_flags();
        bus.PC_IF = 32'h0040_0014; bus.PC_ID = 32'h0040_0010;
        bus.PC_EX = 32'h0040_0010; bus.PC_MEM = 32'h0040_0008;
        bus.IRQ = '0; bus.IRQ_Mask = '0; bus.EPC_In = '0;
        #12;
        chk_comb("reset", 0, 0, 4'b0000, 0, 0);
        chk_reg("reset", 0, 0, 0);
        RST = 1;
        tick();
        chk_comb("idle", 0, 0, 4'b0000, 0, 0);

        // EX overflow
        bus.Exc_EX_Ov = 1; settle();
        chk_comb("ov", 1, 32'h0040_0010, 4'b0111, 1, VEC);
        tick(); bus.Exc_EX_Ov = 0; settle();
        chk_reg("ov", 5'd12, 1, 8'd1);
        chk_comb("ov_after", 0, 0, 4'b0000, 0, 0);

        // Nested BREAK keeps EPC, then ERET
        bus.Exc_ID_Brk = 1; settle();
        chk_comb("brk_nested", 0, 0, 4'b0011, 1, VEC);
        tick(); bus.Exc_ID_Brk = 0; settle();
        chk_reg("brk_nested", 5'd9, 1, 8'd2);
        bus.Eret_ID = 1; bus.EPC_In = 32'h0040_0010; settle();
        chk_comb("eret", 0, 0, 4'b0001, 1, 32'h0040_0010);
        tick(); bus.Eret_ID = 0; settle();
        chk_reg("eret", 5'd9, 0, 8'd2);

        // MEM AdES beats ID Sys
        bus.Exc_MEM_AdES = 1; bus.Exc_ID_Sys = 1; settle();
        chk_comb("ades", 1, 32'h0040_0008, 4'b1111, 1, VEC);
        tick(); clear_flags(); settle();
        chk_reg("ades", 5'd5, 1, 8'd3);
        leave_handler(32'h0040_0008);

        // MEM AdEL beats AdES
        bus.Exc_MEM_AdEL = 1; bus.Exc_MEM_AdES = 1; settle();
        chk_comb("adel_mem", 1, 32'h0040_0008, 4'b1111, 1, VEC);
        tick(); clear_flags(); settle();
        chk_reg("adel_mem", 5'd4, 1, 8'd4);
        leave_handler(32'h0040_0008);

        // Stall holds off ID RI
        bus.Stall = 1; bus.Exc_ID_RI = 1; settle();
        chk_comb("stall_ri", 0, 0, 4'b0000, 0, 0);
        tick();
        chk_reg("stall_ri", 5'd4, 0, 8'd4);
        bus.Stall = 0; settle();
        chk_comb("ri", 1, 32'h0040_0010, 4'b0011, 1, VEC);
        tick(); clear_flags(); settle();
        chk_reg("ri", 5'd10, 1, 8'd5);
        leave_handler(32'h0040_0010);

        // ERET in NORMAL decodes as RI
        bus.Eret_ID = 1; bus.PC_ID = 32'h0040_0020; settle();
        chk_comb("eret_normal", 1, 32'h0040_0020, 4'b0011, 1, VEC);
        tick(); clear_flags(); settle();
        chk_reg("eret_normal", 5'd10, 1, 8'd6);
        leave_handler(32'h0040_0020);

        // IF AdEL flushes IF only
        bus.Exc_IF_AdEL = 1; settle();
        chk_comb("adel_if", 1, 32'h0040_0014, 4'b0001, 1, VEC);
        tick(); clear_flags(); settle();
        chk_reg("adel_if", 5'd4, 1, 8'd7);
        leave_handler(32'h0040_0014);

        // IRQ: taken exactly two edges after the line rises
        bus.IRQ_Mask = 6'b000100; bus.IRQ = 6'b000100; bus.PC_EX = 32'h0040_0030; settle();
        chk_comb("irq_t0", 0, 0, 4'b0000, 0, 0);
        tick();
        chk_comb("irq_t1", 0, 0, 4'b0000, 0, 0);
        tick();
        chk_comb("irq_t2", 1, 32'h0040_0030, 4'b0111, 1, VEC);
        tick();
        chk_reg("irq", 5'd0, 1, 8'd8);
        chk_comb("irq_masked_exl", 0, 0, 4'b0000, 0, 0);
        bus.IRQ = '0;
        tick(); tick(); tick();
        leave_handler(32'h0040_0030);

        // Masked line never taken
        bus.IRQ_Mask = '0; bus.IRQ = 6'b000100;
        for (int i = 0; i < 4; i++) tick();
        chk_comb("irq_mask0", 0, 0, 4'b0000, 0, 0);
        chk_reg("irq_mask0", 5'd0, 0, 8'd8);
        bus.IRQ = '0;
        tick(); tick(); tick();

        // Reset, then saturate the counter
        RST = 0; settle();
        chk_reg("rst2", 0, 0, 0);
        RST = 1;
        tick();
        bus.Exc_EX_Ov = 1;
        for (int i = 0; i < 254; i++) tick();
        chk_reg("sat254", 5'd12, 1, 8'hFE);
        tick();
        chk_reg("sat255", 5'd12, 1, 8'hFF);
        tick();
        chk_reg("sat256", 5'd12, 1, 8'hFF);

        // Async reset mid-handler with a flag still raised
        #2 RST = 0; #1;
        chk_comb("rst_mid", 0, 0, 4'b0000, 0, 0);
        chk_reg("rst_mid", 0, 0, 0);
        clear_flags();
        tick();
        RST = 1;
        tick();
        chk_reg("post_rst", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
